// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage.
// Passes ALU results through to writeback, or runs a single-word load/store
// or a 96-beat bitmap load/store against a req/ack memory port.
//
// state | meaning
// IDLE  | waiting for an instruction; pass-through results written back here
// WORD  | single-word transfer outstanding, waiting for mem_ack
// BURST | bitmap transfer, one 16-bit beat per ack
// DONE  | one-cycle writeback of a load result, then back to IDLE
//
// DONE does not sample in_valid, so execute must not present an instruction
// in the cycle immediately after a memory op completes.
module mem_stage #(
    parameter int BM_WORDS = 96
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    ld,
    input  logic                    st,
    input  logic                    ldb,
    input  logic                    stb,
    input  logic [15:0]             addr,
    input  logic [15:0]             st_data,
    input  logic [16*BM_WORDS-1:0]  bd_data,
    input  logic [3:0]              rd_addr,
    input  logic [1:0]              bd_addr,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [15:0]             mem_addr,
    output logic [15:0]             mem_wdata,
    input  logic [15:0]             mem_rdata,
    input  logic                    mem_ack,
    output logic                    wb_rd_we,
    output logic [3:0]              wb_rd_addr,
    output logic [15:0]             wb_rd_data,
    output logic                    wb_bd_we,
    output logic [1:0]              wb_bd_addr,
    output logic [16*BM_WORDS-1:0]  wb_bd_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WORD  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [6:0] LAST_BEAT = 7'(BM_WORDS - 1);

    logic [1:0]              state_q, state_d;
    logic [6:0]              beat_q, beat_d;
    logic                    we_q, we_d;
    logic [15:0]             addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [3:0]              rd_addr_q, rd_addr_d;
    logic [1:0]              bd_addr_q, bd_addr_d;
    // Holds bitmap store data, the bitmap load buffer, or a pass-through result.
    logic [16*BM_WORDS-1:0]  bd_q, bd_d;
    logic                    wb_rd_we_q, wb_rd_we_d;
    logic [15:0]             wb_rd_data_q, wb_rd_data_d;
    logic                    wb_bd_we_q, wb_bd_we_d;

    logic [10:0]             bit_idx;
    logic                    mem_op;

    assign bit_idx = {beat_q, 4'b0000};
    assign mem_op  = ld | st | ldb | stb;

    // Next-state and capture logic for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_addr_d    = rd_addr_q;
        bd_addr_d    = bd_addr_q;
        bd_d         = bd_q;
        wb_rd_data_d = wb_rd_data_q;
        wb_rd_we_d   = 1'b0;
        wb_bd_we_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d    = addr;
                    wdata_d   = st_data;
                    rd_addr_d = rd_addr;
                    bd_addr_d = bd_addr;
                    bd_d      = bd_data;
                    beat_d    = 7'd0;
                    if (ldb) begin
                        state_d = BURST;
                        we_d    = 1'b0;
                    end else if (stb) begin
                        state_d = BURST;
                        we_d    = 1'b1;
                    end else if (ld) begin
                        state_d = WORD;
                        we_d    = 1'b0;
                    end else if (st) begin
                        state_d = WORD;
                        we_d    = 1'b1;
                    end else begin
                        wb_rd_data_d = addr;
                        wb_rd_we_d   = 1'b1;
                        wb_bd_we_d   = 1'b1;
                    end
                end
            end
            WORD: begin
                if (mem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        wb_rd_data_d = mem_rdata;
                        wb_rd_we_d   = 1'b1;
                    end
                end
            end
            BURST: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        bd_d[bit_idx +: 16] = mem_rdata;
                    end
                    beat_d = beat_q + 7'd1;
                    if (beat_q == LAST_BEAT) begin
                        state_d    = DONE;
                        wb_bd_we_d = !we_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= 7'd0;
            we_q         <= 1'b0;
            addr_q       <= 16'd0;
            wdata_q      <= 16'd0;
            rd_addr_q    <= 4'd0;
            bd_addr_q    <= 2'd0;
            bd_q         <= '0;
            wb_rd_we_q   <= 1'b0;
            wb_rd_data_q <= 16'd0;
            wb_bd_we_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_addr_q    <= rd_addr_d;
            bd_addr_q    <= bd_addr_d;
            bd_q         <= bd_d;
            wb_rd_we_q   <= wb_rd_we_d;
            wb_rd_data_q <= wb_rd_data_d;
            wb_bd_we_q   <= wb_bd_we_d;
        end
    end

    // Memory port is driven only while a transfer is outstanding.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 16'd0;
        mem_wdata = 16'd0;
        case (state_q)
            WORD: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            BURST: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q + {9'd0, beat_q};
                mem_wdata = bd_q[bit_idx +: 16];
            end
            default: begin
                mem_req   = 1'b0;
            end
        endcase
    end

    // Stall is gated by rst_n so it reads 0 while reset is held.
    assign stall = rst_n && ((state_q == WORD) || (state_q == BURST) ||
                             ((state_q == IDLE) && in_valid && mem_op));

    assign wb_rd_we   = wb_rd_we_q;
    assign wb_rd_addr = rd_addr_q;
    assign wb_rd_data = wb_rd_data_q;
    assign wb_bd_we   = wb_bd_we_q;
    assign wb_bd_addr = bd_addr_q;
    assign wb_bd_data = bd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: table vectors, hand-written corner sequences and
// a randomized run checked against a transaction-level reference model.
module tb_mem_stage;
    localparam int BM = 96;
    localparam int W  = 16 * BM;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, ld, st, ldb, stb;
    logic [15:0]   addr, st_data;
    logic [W-1:0]  bd_data;
    logic [3:0]    rd_addr;
    logic [1:0]    bd_addr;
    logic          stall, mem_req, mem_we, mem_ack;
    logic [15:0]   mem_addr, mem_wdata, mem_rdata;
    logic          wb_rd_we, wb_bd_we;
    logic [3:0]    wb_rd_addr;
    logic [15:0]   wb_rd_data;
    logic [1:0]    wb_bd_addr;
    logic [W-1:0]  wb_bd_data;

    mem_stage #(.BM_WORDS(BM)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .ld(ld), .st(st), .ldb(ldb), .stb(stb),
        .addr(addr), .st_data(st_data), .bd_data(bd_data),
        .rd_addr(rd_addr), .bd_addr(bd_addr), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .wb_bd_we(wb_bd_we), .wb_bd_addr(wb_bd_addr), .wb_bd_data(wb_bd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v, ld, st, ldb, stb;
        logic [15:0] addr, sdata;
        logic [3:0]  rd;
        logic [1:0]  bd;
    } instr_t;

    typedef struct {
        instr_t      ins;
        int          dly;
        logic [15:0] rdv;
        bit          exp_stall;
        int          exp_xfers;
        bit          exp_we;
        logic [15:0] exp_maddr;
        logic [15:0] exp_wdata;
        int          exp_req;
        int          exp_rd_n;
        logic [15:0] exp_rd_data;
        logic [3:0]  exp_rd_addr;
        int          exp_bd_n;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit          we;
        logic [15:0] addr, wdata, rdata;
    } xfer_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    xfer_t        xq[$];
    int           rd_n, bd_n, rd_cyc, bd_cyc, req_cycles;
    int           hold_err = 0;
    logic [15:0]  rd_data_seen;
    logic [3:0]   rd_addr_seen;
    logic [1:0]   bd_addr_seen;
    logic [W-1:0] bd_data_seen;
    logic         prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [15:0]  prev_addr = 16'h0, prev_wdata = 16'h0;

    int           dly_lo = 0, dly_hi = 0, wait_left = 0;
    int           rd_mode = 0;
    logic [15:0]  rd_const = 16'h0, salt = 16'h0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] rdata_fn(input logic [15:0] a);
        case (rd_mode)
            0:       return a;
            1:       return rd_const;
            default: return (a * 16'h9E37) ^ salt;
        endcase
    endfunction

    function automatic int first_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 0; k < BM; k++)
            if (a[16*k +: 16] !== b[16*k +: 16]) return k;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack after a programmable number of wait cycles.
    always begin
        @(posedge clk); #1;
        if (rst_n && mem_req) begin
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_fn(mem_addr);
                wait_left = int'($urandom_range(dly_hi, dly_lo));
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wait_left--;
            end
        end else begin
            mem_ack = 1'b0;
        end
    end

    // Monitor: logs completed transfers and writeback pulses mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_req) begin
                req_cycles++;
                if (prev_req && !prev_ack &&
                    (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
                    hold_err++;
                if (mem_ack) xq.push_back('{mem_we, mem_addr, mem_wdata, mem_rdata});
            end
            if (wb_rd_we) begin
                rd_n++; rd_cyc = cyc; rd_data_seen = wb_rd_data; rd_addr_seen = wb_rd_addr;
            end
            if (wb_bd_we) begin
                bd_n++; bd_cyc = cyc; bd_data_seen = wb_bd_data; bd_addr_seen = wb_bd_addr;
            end
        end
        prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we;
        prev_addr = mem_addr; prev_wdata = mem_wdata;
    end

    task automatic clear_logs();
        xq.delete();
        rd_n = 0; bd_n = 0; req_cycles = 0;
    endtask

    task automatic set_delay(input int lo, input int hi);
        dly_lo = lo; dly_hi = hi;
        wait_left = int'($urandom_range(hi, lo));
    endtask

    task automatic apply(input instr_t ins, input logic [W-1:0] bdv);
        in_valid = ins.v; ld = ins.ld; st = ins.st; ldb = ins.ldb; stb = ins.stb;
        addr = ins.addr; st_data = ins.sdata; rd_addr = ins.rd; bd_addr = ins.bd;
        bd_data = bdv;
    endtask

    function automatic logic [W-1:0] rand_bd();
        logic [W-1:0] v;
        for (int k = 0; k < BM; k++) v[16*k +: 16] = 16'($urandom);
        return v;
    endfunction

    // Called just after a rising edge with the DUT idle; returns in IDLE.
    task automatic run_instr(input instr_t ins, input logic [W-1:0] bdv,
                             output bit acc_stall, output int acc_cyc, output bit timed_out);
        clear_logs();
        apply(ins, bdv);
        acc_cyc = cyc;
        #1 acc_stall = stall;
        timed_out = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (mem_req) begin
                in_valid = 1'($urandom);
                {ld, st, ldb, stb} = 4'($urandom);
                addr = 16'($urandom); rd_addr = 4'($urandom);
            end else begin
                in_valid = 1'b0;
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Reference: expected transfers and writebacks from the op rules.
    task automatic check_model(input instr_t ins, input logic [W-1:0] bdv,
                               input bit acc_stall, input int acc_cyc);
        bit is_mem, burst, store, exp_rd, exp_bd;
        int n_exp, bad;
        logic [15:0]  ea, ew;
        logic [W-1:0] ebd;
        is_mem = ins.ld | ins.st | ins.ldb | ins.stb;
        burst  = ins.ldb | ins.stb;
        store  = ins.ldb ? 1'b0 : ins.stb ? 1'b1 : ins.ld ? 1'b0 : ins.st;
        n_exp  = !ins.v ? 0 : burst ? BM : is_mem ? 1 : 0;
        chk("accept_stall", int'(acc_stall), int'(ins.v && is_mem));
        chk("xfer_count", xq.size(), n_exp);
        bad = 0;
        foreach (xq[k]) begin
            if (k < n_exp) begin
                ea = ins.addr + 16'(k);
                ew = burst ? bdv[16*k +: 16] : ins.sdata;
                if (xq[k].we != store || xq[k].addr !== ea || (store && xq[k].wdata !== ew)) bad++;
            end
        end
        chk("xfer_fields", bad, 0);
        exp_rd = ins.v && (!is_mem || (!burst && !store));
        chk("wb_rd_pulses", rd_n, int'(exp_rd));
        if (exp_rd && rd_n == 1) begin
            chk("wb_rd_data", int'(rd_data_seen), int'(is_mem ? rdata_fn(ins.addr) : ins.addr));
            chk("wb_rd_addr", int'(rd_addr_seen), int'(ins.rd));
            if (!is_mem) chk("pt_latency", rd_cyc - acc_cyc, 1);
        end
        exp_bd = ins.v && (!is_mem || (burst && !store));
        chk("wb_bd_pulses", bd_n, int'(exp_bd));
        if (exp_bd && bd_n == 1) begin
            if (is_mem) for (int k = 0; k < BM; k++) ebd[16*k +: 16] = rdata_fn(ins.addr + 16'(k));
            else ebd = bdv;
            chk("wb_bd_data_first_bad_beat", first_diff(bd_data_seen, ebd), -1);
            chk("wb_bd_addr", int'(bd_addr_seen), int'(ins.bd));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[8];
        instr_t       ins;
        logic [W-1:0] bdv;
        bit           s, to, reached;
        int           c, r;

        tbl[0] = '{'{1'b1,1'b0,1'b0,1'b0,1'b0,16'h1234,16'h0000,4'd3,2'd1}, 0, 16'h0000,
                   1'b0, 0, 1'b0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 4'd3, 1, 1};
        tbl[1] = '{'{1'b1,1'b1,1'b0,1'b0,1'b0,16'h0040,16'h0000,4'd5,2'd0}, 3, 16'hBEEF,
                   1'b1, 1, 1'b0, 16'h0040, 16'h0000, 4, 1, 16'hBEEF, 4'd5, 0, 5};
        tbl[2] = '{'{1'b1,1'b0,1'b1,1'b0,1'b0,16'h0100,16'h5A5A,4'd7,2'd0}, 0, 16'h0000,
                   1'b1, 1, 1'b1, 16'h0100, 16'h5A5A, 1, 0, 16'h0000, 4'd0, 0, 0};
        tbl[3] = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,16'h2222,16'h7777,4'd9,2'd0}, 1, 16'h0F0F,
                   1'b1, 1, 1'b0, 16'h2222, 16'h0000, 2, 1, 16'h0F0F, 4'd9, 0, 3};
        tbl[4] = '{'{1'b0,1'b1,1'b0,1'b0,1'b0,16'h3333,16'h0000,4'd1,2'd0}, 0, 16'h0000,
                   1'b0, 0, 1'b0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 4'd0, 0, 0};
        tbl[5] = '{'{1'b1,1'b0,1'b0,1'b0,1'b0,16'hFFFF,16'h0000,4'd15,2'd2}, 0, 16'h0000,
                   1'b0, 0, 1'b0, 16'h0000, 16'h0000, 0, 1, 16'hFFFF, 4'd15, 1, 1};
        tbl[6] = '{'{1'b1,1'b0,1'b1,1'b0,1'b0,16'hFFFF,16'h0001,4'd2,2'd0}, 2, 16'h0000,
                   1'b1, 1, 1'b1, 16'hFFFF, 16'h0001, 3, 0, 16'h0000, 4'd0, 0, 0};
        tbl[7] = '{'{1'b1,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000,4'd0,2'd0}, 0, 16'h8001,
                   1'b1, 1, 1'b0, 16'h0000, 16'h0000, 1, 1, 16'h8001, 4'd0, 0, 2};

        // Reset with a memory op presented: everything must read zero.
        apply('{1'b1,1'b1,1'b0,1'b0,1'b0,16'hABCD,16'h1111,4'd6,2'd3}, rand_bd());
        mem_ack = 1'b0; mem_rdata = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", int'(stall), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_wb_rd_we", int'(wb_rd_we), 0);
        chk("rst_wb_bd_we", int'(wb_bd_we), 0);
        chk("rst_wb_rd_data", int'(wb_rd_data), 0);
        chk("rst_wb_rd_addr", int'(wb_rd_addr), 0);
        chk("rst_wb_bd_addr", int'(wb_bd_addr), 0);
        chk("rst_wb_bd_data_nonzero", int'(|wb_bd_data), 0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven word and pass-through vectors.
        for (int i = 0; i < 8; i++) begin
            rd_mode = 1; rd_const = tbl[i].rdv;
            set_delay(tbl[i].dly, tbl[i].dly);
            bdv = rand_bd();
            run_instr(tbl[i].ins, bdv, s, c, to);
            chk($sformatf("v%0d_timeout", i), int'(to), 0);
            chk($sformatf("v%0d_stall", i), int'(s), int'(tbl[i].exp_stall));
            chk($sformatf("v%0d_xfers", i), xq.size(), tbl[i].exp_xfers);
            if (tbl[i].exp_xfers > 0 && xq.size() > 0) begin
                chk($sformatf("v%0d_mem_we", i), int'(xq[0].we), int'(tbl[i].exp_we));
                chk($sformatf("v%0d_mem_addr", i), int'(xq[0].addr), int'(tbl[i].exp_maddr));
                if (tbl[i].exp_we)
                    chk($sformatf("v%0d_mem_wdata", i), int'(xq[0].wdata), int'(tbl[i].exp_wdata));
            end
            chk($sformatf("v%0d_req_cycles", i), req_cycles, tbl[i].exp_req);
            chk($sformatf("v%0d_rd_pulses", i), rd_n, tbl[i].exp_rd_n);
            if (tbl[i].exp_rd_n == 1 && rd_n == 1) begin
                chk($sformatf("v%0d_rd_data", i), int'(rd_data_seen), int'(tbl[i].exp_rd_data));
                chk($sformatf("v%0d_rd_addr", i), int'(rd_addr_seen), int'(tbl[i].exp_rd_addr));
                chk($sformatf("v%0d_rd_latency", i), rd_cyc - c, tbl[i].exp_lat);
            end
            chk($sformatf("v%0d_bd_pulses", i), bd_n, tbl[i].exp_bd_n);
        end

        // Bitmap store wrapping through 0x0000, beat k carries k.
        rd_mode = 0; set_delay(0, 1);
        for (int k = 0; k < BM; k++) bdv[16*k +: 16] = 16'(k);
        ins = '{1'b1,1'b0,1'b0,1'b0,1'b1,16'hFFF0,16'h0000,4'd0,2'd0};
        run_instr(ins, bdv, s, c, to);
        chk("stb_timeout", int'(to), 0);
        check_model(ins, bdv, s, c);
        if (xq.size() == BM) begin
            chk("stb_first_addr", int'(xq[0].addr), 32'hFFF0);
            chk("stb_last_addr", int'(xq[BM-1].addr), 32'h004F);
            chk("stb_last_wdata", int'(xq[BM-1].wdata), 95);
        end

        // Bitmap load with rdata = address and immediate ack.
        rd_mode = 0; set_delay(0, 0);
        ins = '{1'b1,1'b0,1'b0,1'b1,1'b0,16'h1000,16'h0000,4'd0,2'd2};
        bdv = rand_bd();
        run_instr(ins, bdv, s, c, to);
        chk("ldb_timeout", int'(to), 0);
        check_model(ins, bdv, s, c);
        chk("ldb_req_cycles", req_cycles, BM);

        // ld and ldb together: the burst wins.
        ins = '{1'b1,1'b1,1'b0,1'b1,1'b0,16'h0200,16'h0000,4'd4,2'd1};
        run_instr(ins, bdv, s, c, to);
        chk("ld_ldb_timeout", int'(to), 0);
        check_model(ins, bdv, s, c);

        // Reset at beat 50 of a bitmap load.
        rd_mode = 0; set_delay(0, 0);
        clear_logs();
        apply('{1'b1,1'b0,1'b0,1'b1,1'b0,16'h0800,16'h0000,4'd0,2'd3}, rand_bd());
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (xq.size() == 50) begin reached = 1'b1; break; end
        end
        chk("abort_reached_beat50", int'(reached), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", int'(stall), 0);
        chk("abort_mem_req", int'(mem_req), 0);
        chk("abort_mem_addr", int'(mem_addr), 0);
        chk("abort_mem_wdata", int'(mem_wdata), 0);
        chk("abort_wb_bd_we", int'(wb_bd_we), 0);
        chk("abort_wb_bd_data_nonzero", int'(|wb_bd_data), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        clear_logs();
        repeat (120) @(posedge clk);
        #1;
        chk("abort_no_bd_wb", bd_n, 0);
        chk("abort_no_rd_wb", rd_n, 0);
        chk("abort_no_req", req_cycles, 0);
        ins = '{1'b1,1'b0,1'b0,1'b0,1'b0,16'h4321,16'h0000,4'd8,2'd3};
        bdv = rand_bd();
        run_instr(ins, bdv, s, c, to);
        check_model(ins, bdv, s, c);

        // Randomized instruction stream against the reference model.
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(9, 0));
            ins = '0;
            ins.v = (r != 9);
            if (r == 0) begin
                ins.ldb = 1'b1; {ins.stb, ins.ld, ins.st} = 3'($urandom);
            end else if (r == 1) begin
                ins.stb = 1'b1; {ins.ld, ins.st} = 2'($urandom);
            end else if (r <= 4) begin
                ins.ld = 1'b1; ins.st = 1'($urandom);
            end else if (r <= 6) begin
                ins.st = 1'b1;
            end else if (r == 9) begin
                {ins.ld, ins.st, ins.ldb, ins.stb} = 4'($urandom);
            end
            ins.addr = 16'($urandom); ins.sdata = 16'($urandom);
            ins.rd = 4'($urandom); ins.bd = 2'($urandom);
            rd_mode = 2; salt = 16'($urandom);
            set_delay(0, 2);
            bdv = rand_bd();
            run_instr(ins, bdv, s, c, to);
            chk($sformatf("rand%0d_timeout", n), int'(to), 0);
            check_model(ins, bdv, s, c);
        end

        chk("mem_outputs_held_until_ack", hold_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter BM_WORDS, default 96, meaning the number of 16-bit beats in one 1536-bit bitmap.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning the execute stage presents an instruction.
REQ-005 SHALL have ports ld, st, ldb, stb, input, 1 each, giving the memory op class from decode.
REQ-006 SHALL have port addr, input, 16, the word address (execute rd_data).
REQ-007 SHALL have port st_data, input, 16, the word store data.
REQ-008 SHALL have port bd_data, input, 1536, the bitmap ALU result or bitmap store data.
REQ-009 SHALL have ports rd_addr (input, 4) and bd_addr (input, 2), the destination register indices.
REQ-010 SHALL have port stall, output, 1, meaning execute holds its inputs.
REQ-011 SHALL have memory ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 16), mem_wdata (output, 16), mem_rdata (input, 16) and mem_ack (input, 1).
REQ-012 SHALL have writeback ports wb_rd_we (output, 1), wb_rd_addr (output, 4), wb_rd_data (output, 16), wb_bd_we (output, 1), wb_bd_addr (output, 2) and wb_bd_data (output, 1536).

Function
REQ-013 SHALL implement FSM states IDLE, WORD, BURST and DONE.
REQ-014 SHALL, in IDLE with in_valid and no memory op, register rd_data=addr and bd_data into the wb outputs next cycle with wb_rd_we=1 and wb_bd_we=1 (latency 1, no stall).
REQ-015 SHALL resolve simultaneous op bits by priority ldb > stb > ld > st; lower-priority bits are ignored.
REQ-016 SHALL, in IDLE with ld or st, capture all inputs and enter WORD; in WORD, assert mem_req=1, mem_addr=addr and mem_we=st, with mem_wdata=st_data.
REQ-017 SHALL hold mem_req and all mem_* outputs stable until the cycle mem_ack=1; a transfer completes only on a cycle with mem_req=1 and mem_ack=1.
REQ-018 SHALL, on ld completion, drive wb_rd_data=mem_rdata and wb_rd_we=1 for one cycle in DONE; on st completion, pulse no wb enable.
REQ-019 SHALL, in IDLE with ldb or stb, capture inputs, clear a 7-bit beat counter and enter BURST.
REQ-020 SHALL, in BURST, drive mem_addr=addr+beat (16-bit wrap-around, 0xFFFF+1=0x0000) and mem_we=stb, with mem_wdata=bd_data[16*beat+15:16*beat].
REQ-021 SHALL, on each ldb beat ack, write mem_rdata into bits [16*beat+15:16*beat] of an internal 1536-bit buffer.
REQ-022 SHALL increment beat on each ack; the ack at beat=BM_WORDS-1 moves the FSM to DONE.
REQ-023 SHALL, in DONE after ldb, drive wb_bd_data=buffer and wb_bd_we=1 for one cycle; after stb, pulse no wb enable.
REQ-024 SHALL return DONE to IDLE unconditionally after one cycle.
REQ-025 SHALL drive stall=1 in WORD and BURST, and in IDLE in the cycle a memory op is accepted; stall=0 in DONE and otherwise.
REQ-026 SHALL ignore in_valid when stall=1.
REQ-027 SHALL deassert wb_rd_we and wb_bd_we in every cycle not named in REQ-014, REQ-018 or REQ-023.
REQ-028 SHALL ensure mem_req is never asserted in IDLE or DONE.

Reset
REQ-029 SHALL, when rst_n=0, immediately force state=IDLE, beat=0 and stall=0, with mem_req, mem_we, wb_rd_we and wb_bd_we all 0 and all data/address outputs 0.
REQ-030 SHALL, on reset asserted mid-WORD or mid-BURST, abandon the transfer, and SHALL issue no writeback after reset release.

Verification
REQ-031 SHALL pass: in_valid with no op, addr=0x1234, rd_addr=3 -> next cycle wb_rd_we=1, wb_rd_addr=3, wb_rd_data=0x1234, stall=0.
REQ-032 SHALL pass: ld addr=0x0040 with mem_ack delayed 3 cycles and mem_rdata=0xBEEF -> mem_req held for 4 cycles at 0x0040, then wb_rd_data=0xBEEF with wb_rd_we pulsed once.
REQ-033 SHALL pass: stb addr=0xFFF0 with bd_data beat k=k -> 96 writes at addresses 0xFFF0..0x004F (wrapping through 0x0000), with wdata 0..95 and no wb enable.
REQ-034 SHALL pass: ldb with mem_rdata=mem_addr and immediate ack -> wb_bd_data beat k=addr+k and wb_bd_we pulsed exactly once after 96 beats.
REQ-035 SHALL pass: ld and ldb asserted together -> burst of 96 beats occurs and no word writeback.
REQ-036 SHALL pass: rst_n=0 at beat 50 of ldb -> outputs zero immediately, IDLE after release, no wb_bd_we pulse.
